instr_cache: RTL

- Direct-mapped instruction cache that sits between the fetch stage's PC and a word-wide backing instruction memory.
- It answers fetch lookups combinationally on a hit, so single-cycle fetch is preserved.
- On a miss it raises stall and refills the whole line over a req/ack handshake.
- It is the responder side of the fetch-address interface; the fetch stage is the requester.

---
 rtl/icache_pkg.sv | 36 +++
 rtl/icache_array.sv | 62 ++++++
 rtl/instr_cache.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the refill FSM state type, the default geometry and its derived field widths, and
// address-field extraction helpers. The helpers take the field widths as arguments so
// modules with non-default parameters can reuse them.
package icache_pkg;

   localparam int unsigned ADDRESS_WIDTH_DEF  = 32;
   localparam int unsigned DATA_WIDTH_DEF     = 32;
   localparam int unsigned SETS_DEF           = 16;
   localparam int unsigned WORDS_PER_LINE_DEF = 4;

   localparam int unsigned WB       = $clog2(WORDS_PER_LINE_DEF);
   localparam int unsigned SET_BITS = $clog2(SETS_DEF);
   localparam int unsigned TAG_BITS = ADDRESS_WIDTH_DEF - SET_BITS - WB - 2;

   typedef enum logic [0:0] {IDLE, REFILL} state_t;

   function automatic logic [63:0] addr_field(logic [63:0] addr, int unsigned lsb,
                                              int unsigned bits);
      return (addr >> lsb) & ((64'd1 << bits) - 64'd1);
   endfunction

   function automatic logic [63:0] word_of(logic [63:0] addr, int unsigned wb);
      return addr_field(addr, 2, wb);
   endfunction

   function automatic logic [63:0] set_of(logic [63:0] addr, int unsigned wb, int unsigned sb);
      return addr_field(addr, 2 + wb, sb);
   endfunction

   function automatic logic [63:0] tag_of(logic [63:0] addr, int unsigned wb, int unsigned sb,
                                          int unsigned tb);
      return addr_field(addr, 2 + wb + sb, tb);
   endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache.
// Ports:
//   clk, rst        clock, synchronous active-low reset (clears valid bits only)
//   rd_set/rd_word  combinational read address -> rd_valid, rd_tag, rd_data
//   wr_en/wr_set/wr_word/wr_data  single data word write
//   tag_we/tag_set/tag/tag_valid  tag write plus valid bit update for one line
//   clear_all       invalidate every line (wins over a same-cycle tag_valid)
module icache_array #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned SETS           = 16,
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned TAG_BITS       = 24
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [$clog2(SETS)-1:0]           rd_set,
   input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_word,
   output logic                              rd_valid,
   output logic [TAG_BITS-1:0]               rd_tag,
   output logic [DATA_WIDTH-1:0]             rd_data,
   input  logic                              wr_en,
   input  logic [$clog2(SETS)-1:0]           wr_set,
   input  logic [$clog2(WORDS_PER_LINE)-1:0] wr_word,
   input  logic [DATA_WIDTH-1:0]             wr_data,
   input  logic                              tag_we,
   input  logic [$clog2(SETS)-1:0]           tag_set,
   input  logic [TAG_BITS-1:0]               tag,
   input  logic                              tag_valid,
   input  logic                              clear_all
);

   logic [SETS-1:0]       valid_q;
   logic [TAG_BITS-1:0]   tag_q  [SETS];
   logic [DATA_WIDTH-1:0] data_q [SETS][WORDS_PER_LINE];

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (clear_all) begin
         valid_q <= '0;
      end else if (tag_we) begin
         valid_q[tag_set] <= tag_valid;
      end
   end

   // Tag and data storage is deliberately not reset; valid bits gate every use.
   always_ff @(posedge clk) begin
      if (tag_we) begin
         tag_q[tag_set] <= tag;
      end
      if (wr_en) begin
         data_q[wr_set][wr_word] <= wr_data;
      end
   end

   always_comb begin
      rd_valid = valid_q[rd_set];
      rd_tag   = tag_q[rd_set];
      rd_data  = data_q[rd_set][rd_word];
   end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache between the fetch PC and a word-wide backing memory.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   fetch_valid/addr    lookup from fetch stage; hit answered in the same cycle
//   flush               invalidate all lines (deferred to end of an active refill)
//   instr/instr_valid   hit data (0 when not valid)
//   stall               fetch must hold its PC
//   mem_req/addr/ack/rdata  line refill handshake, one word per ack
module instr_cache
   import icache_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH  = ADDRESS_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int unsigned SETS           = SETS_DEF,
   parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fetch_valid,
   input  logic [ADDRESS_WIDTH-1:0] fetch_addr,
   input  logic                     flush,
   output logic [DATA_WIDTH-1:0]    instr,
   output logic                     instr_valid,
   output logic                     stall,
   output logic                     mem_req,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   input  logic                     mem_ack,
   input  logic [DATA_WIDTH-1:0]    mem_rdata
);

   localparam int unsigned LWB = $clog2(WORDS_PER_LINE);
   localparam int unsigned LSB = $clog2(SETS);
   localparam int unsigned LTB = ADDRESS_WIDTH - LSB - LWB - 2;
   localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK = ADDRESS_WIDTH'(WORDS_PER_LINE * 4 - 1);
   localparam logic [LWB-1:0] LAST_WORD = LWB'(WORDS_PER_LINE - 1);

   state_t                   state_q, state_d;
   logic [LWB-1:0]           cnt_q, cnt_d;
   logic [ADDRESS_WIDTH-1:0] base_q, base_d;
   logic                     pend_q, pend_d;

   logic [LWB-1:0]        f_word;
   logic [LSB-1:0]        f_set, r_set;
   logic [LTB-1:0]        f_tag, r_tag;
   logic                  rd_valid, hit;
   logic [LTB-1:0]        rd_tag;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  wr_en, tag_we, tag_valid, clear_all;

   assign f_word = LWB'(word_of(64'(fetch_addr), LWB));
   assign f_set  = LSB'(set_of(64'(fetch_addr), LWB, LSB));
   assign f_tag  = LTB'(tag_of(64'(fetch_addr), LWB, LSB, LTB));
   assign r_set  = LSB'(set_of(64'(base_q), LWB, LSB));
   assign r_tag  = LTB'(tag_of(64'(base_q), LWB, LSB, LTB));
   assign hit    = fetch_valid & rd_valid & (rd_tag == f_tag);

   icache_array #(
      .DATA_WIDTH     (DATA_WIDTH),
      .SETS           (SETS),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .TAG_BITS       (LTB)
   ) u_array (
      .clk       (clk),
      .rst       (rst),
      .rd_set    (f_set),
      .rd_word   (f_word),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .wr_en     (wr_en),
      .wr_set    (r_set),
      .wr_word   (cnt_q),
      .wr_data   (mem_rdata),
      .tag_we    (tag_we),
      .tag_set   (r_set),
      .tag       (r_tag),
      .tag_valid (tag_valid),
      .clear_all (clear_all)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      base_d      = base_q;
      pend_d      = pend_q;
      instr       = '0;
      instr_valid = 1'b0;
      stall       = 1'b0;
      mem_req     = 1'b0;
      mem_addr    = '0;
      wr_en       = 1'b0;
      tag_we      = 1'b0;
      tag_valid   = 1'b0;
      clear_all   = 1'b0;
      // While reset is asserted every output and array write stays quiet.
      if (rst) begin
         unique case (state_q)
            IDLE: begin
               if (flush) begin
                  clear_all = 1'b1;
               end else if (hit) begin
                  instr_valid = 1'b1;
                  instr       = rd_data;
               end else if (fetch_valid) begin
                  stall   = 1'b1;
                  base_d  = fetch_addr & ~LINE_MASK;
                  cnt_d   = '0;
                  state_d = REFILL;
               end
            end
            REFILL: begin
               stall    = 1'b1;
               mem_req  = 1'b1;
               mem_addr = base_q + (ADDRESS_WIDTH'(cnt_q) << 2);
               if (flush) begin
                  pend_d = 1'b1;
               end
               if (mem_ack) begin
                  wr_en = 1'b1;
                  cnt_d = cnt_q + LWB'(1);
                  if (cnt_q == LAST_WORD) begin
                     // A flush seen at any point of the refill leaves the new line invalid.
                     tag_we    = 1'b1;
                     tag_valid = ~(pend_q | flush);
                     clear_all = pend_q | flush;
                     pend_d    = 1'b0;
                     state_d   = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         pend_q  <= pend_d;
      end
   end

endmodule
